// File: rtl/fibo_pkg.sv
// Shared types and widths for the Fibonacci request sequencer.
//   seq_state_t : sequencer FSM state (IDLE, ISSUE, WAIT, RESP)
//   FIBO_N_W    : width of a Fibonacci index
//   FIBO_RES_W  : width of a calculator result
package fibo_pkg;
  localparam int FIBO_N_W   = 5;
  localparam int FIBO_RES_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/fibo_req_fifo.sv
// Synchronous FIFO holding queued {index, tag} requests.
// Ports:
//   clk, reset_n     : clock, async active-low reset (empties the queue)
//   push, wdata      : write request (ignored when full)
//   pop              : remove head (ignored when empty)
//   rdata            : current head entry (valid while !empty)
//   full, empty      : occupancy flags
module fibo_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  r_wptr, r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push, w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign empty  = (r_wptr == r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign rdata  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fibo_req_sequencer.sv
// Queues Fibonacci requests and feeds them one at a time to an external
// calculator, returning each result with its caller tag.
// Ports:
//   clk, reset_n                   : clock, async active-low reset
//   req_valid/req_ready/req_n/req_tag : request input (queued, FIFO order)
//   calc_input_s, calc_begin       : index and start pulse to calculator
//   calc_result, calc_done         : calculator result and valid pulse
//   rsp_valid/rsp_ready/rsp_value/rsp_tag/rsp_err : response handshake
//   busy                           : FSM not idle or queue non-empty
// Build option: FIBO_SEQ_TIMEOUT_EN enables a WAIT watchdog that answers
// with rsp_err=1, rsp_value=0 after TIMEOUT_CYCLES cycles without calc_done.
module fibo_req_sequencer
  import fibo_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_W          = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FIBO_N_W-1:0]   req_n,
  input  logic [TAG_W-1:0]      req_tag,
  output logic [FIBO_N_W-1:0]   calc_input_s,
  output logic                  calc_begin,
  input  logic [FIBO_RES_W-1:0] calc_result,
  input  logic                  calc_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [FIBO_RES_W-1:0] rsp_value,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  rsp_err,
  output logic                  busy
);
  localparam int QW = FIBO_N_W + TAG_W;

  if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("fibo_req_sequencer: FIFO_DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  seq_state_t          r_state, w_next;
  logic [FIBO_N_W-1:0] r_n;
  logic [TAG_W-1:0]    r_tag;
  logic [FIBO_RES_W-1:0] r_value;
  logic [QW-1:0]       w_head;
  logic                w_full, w_empty, w_push, w_pop, w_cap, w_tmo;

  // Ready is held low while reset is asserted even though the queue is empty.
  assign req_ready = reset_n & ~w_full;
  assign w_push    = req_valid & req_ready;

  fibo_req_fifo #(.DEPTH(FIFO_DEPTH), .W(QW)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (w_push),
    .wdata  ({req_n, req_tag}),
    .pop    (w_pop),
    .rdata  (w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

`ifdef FIBO_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wcnt;
  logic          r_err;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_cap  = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      IDLE:  if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = ISSUE;
             end
      ISSUE: w_next = WAIT;
      WAIT:  if (calc_done) begin
               w_cap  = 1'b1;
               w_next = RESP;
             end
`ifdef FIBO_SEQ_TIMEOUT_EN
             // r_wcnt counts completed WAIT cycles; the last allowed one ends here.
             else if (r_wcnt == CW'(TIMEOUT_CYCLES - 1)) begin
               w_tmo  = 1'b1;
               w_next = RESP;
             end
`endif
      RESP:  if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n     <= '0;
      r_tag   <= '0;
      r_value <= '0;
    end else begin
      if (w_pop) {r_n, r_tag} <= w_head;
      if (w_cap)      r_value <= calc_result;
      else if (w_tmo) r_value <= '0;
    end
  end

`ifdef FIBO_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= (r_state == WAIT) ? r_wcnt + 1'b1 : '0;
      if (w_cap)      r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign calc_begin   = (r_state == ISSUE);
  assign calc_input_s = (r_state == ISSUE || r_state == WAIT) ? r_n : '0;
  assign rsp_valid    = (r_state == RESP);
  assign rsp_value    = r_value;
  assign rsp_tag      = r_tag;
  assign busy         = (r_state != IDLE) || !w_empty;
endmodule
